// File: rtl/nn_burst_gen.sv
// Spike burst generator: emits NBURST bursts of BURST_LENGTH high cycles, each followed by GAP_LENGTH low cycles.
// Latency: first OUT=1 one cycle after START is accepted; all outputs registered.
module nn_burst_gen #(
    parameter int BURST_LENGTH = 8,
    parameter int GAP_LENGTH   = 10,
    parameter int COUNT_WIDTH  = 8,
    parameter int COUNTER_SIZE = 8
) (
    input  logic                   CLK,
    input  logic                   INIT,
    input  logic                   START,
    input  logic [COUNT_WIDTH-1:0] NBURST,
    input  logic                   ABORT,
    output logic                   READY,
    output logic                   OUT,
    output logic                   DONE,
    output logic [COUNT_WIDTH-1:0] REMAINING
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [COUNTER_SIZE-1:0] BURST_LAST = COUNTER_SIZE'(BURST_LENGTH - 1);
    localparam logic [COUNTER_SIZE-1:0] GAP_LAST   = COUNTER_SIZE'(GAP_LENGTH - 1);

    logic [1:0]              state;
    logic [COUNTER_SIZE-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            OUT       <= 1'b0;
            READY     <= 1'b1;
            DONE      <= 1'b0;
            REMAINING <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // ABORT is meaningless here, so START always wins.
                    if (START) begin
                        if (NBURST != '0) begin
                            state     <= ST_BURST;
                            OUT       <= 1'b1;
                            READY     <= 1'b0;
                            cnt       <= '0;
                            REMAINING <= NBURST - COUNT_WIDTH'(1);
                        end else begin
                            DONE <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (ABORT) begin
                        state     <= ST_GAP;
                        OUT       <= 1'b0;
                        cnt       <= '0;
                        REMAINING <= '0;
                    end else if (cnt == BURST_LAST) begin
                        state <= ST_GAP;
                        OUT   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + COUNTER_SIZE'(1);
                    end
                end
                ST_GAP: begin
                    if (ABORT) begin
                        REMAINING <= '0;
                    end
                    // The gap always runs to completion so the downstream detector can recover.
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (ABORT || (REMAINING == '0)) begin
                            state <= ST_IDLE;
                            READY <= 1'b1;
                            DONE  <= 1'b1;
                        end else begin
                            state     <= ST_BURST;
                            OUT       <= 1'b1;
                            REMAINING <= REMAINING - COUNT_WIDTH'(1);
                        end
                    end else begin
                        cnt <= cnt + COUNTER_SIZE'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    OUT       <= 1'b0;
                    READY     <= 1'b1;
                    REMAINING <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_burst_gen.sv
// Directed bench for nn_burst_gen: per-cycle expectations queued at stimulus time, popped and checked each cycle.
module tb_nn_burst_gen;

    localparam int L = 8;
    localparam int G = 10;
    localparam int P = L + G;

    logic       CLK;
    logic       INIT;
    logic       START;
    logic [7:0] NBURST;
    logic       ABORT;
    logic       READY;
    logic       OUT;
    logic       DONE;
    logic [7:0] REMAINING;

    typedef struct {
        logic       o;
        logic       r;
        logic       d;
        logic [7:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run    = 0;
    int   fires  = 0;

    nn_burst_gen #(
        .BURST_LENGTH(L),
        .GAP_LENGTH  (G),
        .COUNT_WIDTH (8),
        .COUNTER_SIZE(8)
    ) dut (
        .CLK      (CLK),
        .INIT     (INIT),
        .START    (START),
        .NBURST   (NBURST),
        .ABORT    (ABORT),
        .READY    (READY),
        .OUT      (OUT),
        .DONE     (DONE),
        .REMAINING(REMAINING)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic push_exp(input logic o, input logic r, input logic d, input int rem);
        exp_t e;
        e.o   = o;
        e.r   = r;
        e.d   = d;
        e.rem = 8'(rem);
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_exp(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Expected cycles 1 .. N*P+1 after an accepted request, straight from the burst timing formulas.
    task automatic push_req(input int n);
        for (int c = 1; c <= n * P + 1; c++) begin
            if (c <= n * P)
                push_exp(((c - 1) % P) < L, 1'b0, 1'b0, n - 1 - (c - 1) / P);
            else
                push_exp(1'b0, 1'b1, 1'b1, 0);
        end
    endtask

    task automatic check_now(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".out"},   32'(OUT),       32'(e.o));
            chk({tag, ".ready"}, 32'(READY),     32'(e.r));
            chk({tag, ".done"},  32'(DONE),      32'(e.d));
            chk({tag, ".rem"},   32'(REMAINING), 32'(e.rem));
        end
    endtask

    task automatic tick(input string tag);
        @(negedge CLK);
        check_now(tag);
        // Window-of-8 burst-gate detector: fires once when a high run reaches 8.
        if (OUT === 1'b1) begin
            run++;
            if (run == 8) fires++;
        end else begin
            run = 0;
        end
    endtask

    initial begin
        INIT   = 1'b1;
        START  = 1'b0;
        NBURST = 8'd0;
        ABORT  = 1'b0;

        repeat (3) begin
            START  = 1'($urandom_range(0, 1));
            NBURST = 8'($urandom);
            ABORT  = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        push_idle(1);
        check_now("reset");
        INIT   = 1'b0;
        START  = 1'b0;
        ABORT  = 1'b0;
        NBURST = 8'd0;
        push_idle(2);
        tick("idle");
        tick("idle");

        // NBURST=3 with START pulses while busy that must be ignored
        START  = 1'b1;
        NBURST = 8'd3;
        push_req(3);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick("n3");
            START  = (c == 10 || c == 30 || c == 50);
            NBURST = 8'd7;
        end
        push_idle(1);
        tick("n3_post");

        // NBURST=0: immediate DONE, never busy
        START  = 1'b1;
        NBURST = 8'd0;
        push_exp(1'b0, 1'b1, 1'b1, 0);
        tick("n0");
        START = 1'b0;
        push_idle(2);
        tick("n0_post");
        tick("n0_post");

        // ABORT in IDLE ignored
        ABORT = 1'b1;
        push_idle(1);
        tick("abort_idle");
        ABORT = 1'b0;

        // START+ABORT together (START wins), then ABORT on 4th high cycle
        START  = 1'b1;
        ABORT  = 1'b1;
        NBURST = 8'd5;
        for (int c = 1; c <= 4; c++) push_exp(1'b1, 1'b0, 1'b0, 4);
        for (int c = 5; c <= 14; c++) push_exp(1'b0, 1'b0, 1'b0, 0);
        push_exp(1'b0, 1'b1, 1'b1, 0);
        push_idle(1);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick("abort_burst");
            START = 1'b0;
            ABORT = (c == 4);
        end

        // ABORT during the first gap: gap completes, no further bursts
        START  = 1'b1;
        NBURST = 8'd3;
        for (int c = 1; c <= 8; c++) push_exp(1'b1, 1'b0, 1'b0, 2);
        for (int c = 9; c <= 12; c++) push_exp(1'b0, 1'b0, 1'b0, 2);
        for (int c = 13; c <= 18; c++) push_exp(1'b0, 1'b0, 1'b0, 0);
        push_exp(1'b0, 1'b1, 1'b1, 0);
        push_idle(1);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick("abort_gap");
            START = 1'b0;
            ABORT = (c == 12);
        end

        // Back-to-back: START held, second request taken in the DONE cycle
        START  = 1'b1;
        NBURST = 8'd2;
        push_req(2);
        push_req(2);
        push_idle(1);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick("b2b");
            if (c == 40) START = 1'b0;
        end

        // INIT mid-burst: OUT drops next cycle, no DONE
        START  = 1'b1;
        NBURST = 8'd3;
        for (int c = 1; c <= 3; c++) push_exp(1'b1, 1'b0, 1'b0, 2);
        push_idle(3);
        for (int c = 1; exp_q.size() > 0; c++) begin
            tick("init_mid");
            START = 1'b0;
            INIT  = (c == 3);
        end

        // Loopback into the burst-gate detector across 20 bursts
        fires  = 0;
        run    = 0;
        START  = 1'b1;
        NBURST = 8'd20;
        push_req(20);
        while (exp_q.size() > 0) begin
            tick("loop");
            START = 1'b0;
        end
        chk("loopback_fires", 32'(fires), 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_burst_gen.md
# nn_burst_gen

Spike burst generator: the transmit side of the burst-gate protocol. On a single-cycle request it emits NBURST bursts on a single-bit spike line. Each burst is BURST_LENGTH consecutive high cycles followed by GAP_LENGTH low cycles, so a downstream burst-gate detector with window length ≤ BURST_LENGTH fires exactly once per burst and has finished its refractory period before the next burst. It sits between a neuron's spike-count logic and the stochastic interconnect feeding the next layer's burst gates.

## Interface
- BURST_LENGTH, 8: high cycles per burst; must be ≥1 and fit in COUNTER_SIZE bits.
- GAP_LENGTH, 10: low cycles after every burst, including the last one; must be ≥1 and fit in COUNTER_SIZE bits.
- COUNT_WIDTH, 8: width of the burst-count request.
- COUNTER_SIZE, 8: width of the internal phase counter.
- CLK  in  1  clock; all logic on rising edge.
- INIT  in  1  reset, synchronous and active-high.
- START  in  1  request strobe; sampled only when READY=1.
- NBURST  in  COUNT_WIDTH  number of bursts to send; captured with START.
- ABORT  in  1  terminate the current request early.
- READY  out  1  idle; a new request is accepted.
- OUT  out  1  spike line (registered).
- DONE  out  1  one-cycle pulse on request completion.
- REMAINING  out  COUNT_WIDTH  bursts not yet started (registered).

## Operation
- States: IDLE, BURST, GAP.
- Reset (INIT=1 at an edge, any state): state=IDLE, OUT=0, READY=1, DONE=0, REMAINING=0, phase counter=0. This applies mid-burst too; no DONE is generated for a request killed by INIT.
- IDLE: READY=1, OUT=0.
  - START=1 with NBURST≠0 → BURST next cycle; REMAINING←NBURST−1; counter←0.
  - START=1 with NBURST=0 → stay IDLE; DONE=1 next cycle; READY stays 1.
- BURST: OUT=1; counter increments each cycle.
  - On the cycle counter reaches BURST_LENGTH−1 → GAP next cycle; counter←0.
- GAP: OUT=0; counter increments each cycle.
  - On the cycle counter reaches GAP_LENGTH−1:
    - REMAINING≠0 → BURST next cycle; REMAINING decrements.
    - REMAINING=0 → IDLE next cycle; DONE=1 and READY=1 in that same cycle.
- ABORT=1 in BURST → GAP next cycle; OUT=0; counter←0; REMAINING←0. The full gap still runs, then IDLE with DONE.
- ABORT=1 in GAP → REMAINING←0; the current gap completes normally, then IDLE with DONE.
- ABORT in IDLE: ignored.
- ABORT and START in the same IDLE cycle: START wins.
- START while READY=0: ignored; no queuing.
- INIT has priority over ABORT, which has priority over normal sequencing.
- Counter compare uses `==` against the parameter minus 1, at COUNTER_SIZE width; no wrap is possible for legal parameters.

## Timing
- Request accepted at edge t (START=1, READY=1, NBURST=N≥1).
- Burst k (k=0..N−1):
  - OUT=1 for cycles t+1+k·P … t+k·P+L, where L=BURST_LENGTH, G=GAP_LENGTH, P=L+G.
  - OUT=0 for the following G cycles.
- READY=0 for cycles t+1 … t+N·P.
- READY=1 and DONE=1 in cycle t+N·P+1.
- A new START sampled in that cycle is accepted; its first OUT=1 is at t+N·P+2. The inter-request gap is therefore G+1 cycles.
- DONE is never high for more than one consecutive cycle.
- NBURST=0 request: DONE in cycle t+1; OUT stays 0.
- ABORT sampled in BURST at edge a: OUT=0 from cycle a+1; DONE at cycle a+G+1.
- REMAINING updates on the edge where a burst starts. It is never seen at N in BURST; the first burst already shows N−1.

## Test plan
- Reset: hold INIT 3 cycles from random state → OUT=0, READY=1, DONE=0, REMAINING=0. Repeat with INIT asserted mid-burst: OUT=0 the next cycle, no DONE.
- Defaults, NBURST=3, START at t=0:
  - OUT high cycles 1–8, 19–26, 37–44; low elsewhere.
  - READY=0 cycles 1–54.
  - DONE and READY=1 at cycle 55.
  - REMAINING reads 2, 1, 0 during bursts 0, 1, 2.
- NBURST=0: DONE at cycle 1, OUT never high, READY never low. START pulses while busy (NBURST=3 run) → ignored; total bursts still 3.
- ABORT on the 4th high cycle of burst 0 (NBURST=5) → OUT low from next cycle; exactly 10 low cycles; DONE after them; total high cycles = 4.
- Back-to-back: START held high continuously with NBURST=2 → second request accepted in the DONE cycle. Gap between bursts of different requests is 11 cycles; within a request it is 10.
- Loopback: drive OUT into an 8-bit burst-gate detector → exactly one detector firing per burst, none missed across 20 bursts.
